// File: rtl/usrt_tx_ctrl.sv
// USRT transmit sequencer: frames one byte as start, LSB-first data, optional
// even parity and stop, driving the serial line and a synchronous bit clock.
module usrt_tx_ctrl #(
    parameter int BAUD_W = 14,
    parameter int DATA_W = 8
) (
    input  logic              i_Pclk,
    input  logic              i_Presetn,
    input  logic              i_Start,
    input  logic [DATA_W-1:0] i_Data,
    input  logic              i_Parity,
    input  logic [BAUD_W-1:0] i_Baud,
    output logic              o_Tx,
    output logic              o_Sclk,
    output logic              o_Busy,
    output logic              o_Done
);

    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t              state_q;
    logic [BAUD_W-1:0]   baud_q;
    logic [BAUD_W-1:0]   cnt_q;
    logic [BAUD_W-1:0]   cnt_d;
    logic [IDX_W-1:0]    idx_q;
    logic [DATA_W-1:0]   shift_q;
    logic                par_en_q;
    logic                par_bit_q;
    logic                tx_q;
    logic                sclk_q;
    logic                busy_q;
    logic                done_q;
    logic                bit_end;

    always_comb begin
        cnt_d   = cnt_q + BAUD_W'(1);
        bit_end = (cnt_q == (baud_q - BAUD_W'(1)));
    end

    // Outputs are registered: each value is set one edge ahead of the cycle it describes.
    always_ff @(posedge i_Pclk or negedge i_Presetn) begin
        if (!i_Presetn) begin
            state_q   <= IDLE;
            baud_q    <= '0;
            cnt_q     <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            tx_q      <= 1'b1;
            sclk_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    tx_q   <= 1'b1;
                    sclk_q <= 1'b0;
                    busy_q <= 1'b0;
                    if (i_Start) begin
                        shift_q   <= i_Data;
                        par_en_q  <= i_Parity;
                        par_bit_q <= ^i_Data;
                        baud_q    <= (i_Baud < BAUD_W'(2)) ? BAUD_W'(2) : i_Baud;
                        cnt_q     <= '0;
                        idx_q     <= '0;
                        tx_q      <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= START;
                    end
                end
                default: begin
                    if (!bit_end) begin
                        cnt_q  <= cnt_d;
                        sclk_q <= (cnt_d >= (baud_q >> 1));
                    end else begin
                        cnt_q  <= '0;
                        sclk_q <= 1'b0;
                        case (state_q)
                            START: begin
                                tx_q    <= shift_q[0];
                                shift_q <= shift_q >> 1;
                                state_q <= DATA;
                            end
                            DATA: begin
                                if (idx_q == IDX_W'(DATA_W - 1)) begin
                                    idx_q <= '0;
                                    if (par_en_q) begin
                                        tx_q    <= par_bit_q;
                                        state_q <= PARITY;
                                    end else begin
                                        tx_q    <= 1'b1;
                                        state_q <= STOP;
                                    end
                                end else begin
                                    idx_q   <= idx_q + IDX_W'(1);
                                    tx_q    <= shift_q[0];
                                    shift_q <= shift_q >> 1;
                                end
                            end
                            PARITY: begin
                                tx_q    <= 1'b1;
                                state_q <= STOP;
                            end
                            default: begin
                                tx_q    <= 1'b1;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                                state_q <= IDLE;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    assign o_Tx   = tx_q;
    assign o_Sclk = sclk_q;
    assign o_Busy = busy_q;
    assign o_Done = done_q;

endmodule

// File: tb/tb_usrt_tx_ctrl.sv
// Directed bench for usrt_tx_ctrl: hand-written bit sequences checked cycle by
// cycle on the falling clock edge.
module tb_usrt_tx_ctrl;

    logic        i_Pclk;
    logic        i_Presetn;
    logic        i_Start;
    logic [7:0]  i_Data;
    logic        i_Parity;
    logic [13:0] i_Baud;
    logic        o_Tx;
    logic        o_Sclk;
    logic        o_Busy;
    logic        o_Done;

    int checks = 0;
    int errors = 0;
    bit seq [12];

    usrt_tx_ctrl #(.BAUD_W(14), .DATA_W(8)) dut (
        .i_Pclk    (i_Pclk),
        .i_Presetn (i_Presetn),
        .i_Start   (i_Start),
        .i_Data    (i_Data),
        .i_Parity  (i_Parity),
        .i_Baud    (i_Baud),
        .o_Tx      (o_Tx),
        .o_Sclk    (o_Sclk),
        .o_Busy    (o_Busy),
        .o_Done    (o_Done)
    );

    initial i_Pclk = 1'b0;
    always #5 i_Pclk = ~i_Pclk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Called at the falling edge of the first busy cycle; returns in the done cycle.
    // At cycle 'poke' of the frame the config is disturbed and i_Start pulsed.
    task automatic check_frame(input string name, input int nb, input int beff, input int poke);
        int cyc = 0;
        for (int b = 0; b < nb; b++) begin
            for (int c = 0; c < beff; c++) begin
                chk({name, " tx"},   o_Tx,   seq[b]);
                chk({name, " sclk"}, o_Sclk, (c >= beff / 2));
                chk({name, " busy"}, o_Busy, 1'b1);
                chk({name, " done"}, o_Done, 1'b0);
                if (cyc == poke) begin
                    i_Baud   = 14'd3;
                    i_Parity = 1'b1;
                    i_Start  = 1'b1;
                end else if (poke >= 0 && cyc == poke + 1) begin
                    i_Start = 1'b0;
                end
                cyc++;
                @(negedge i_Pclk);
            end
        end
        chk({name, " end busy"}, o_Busy, 1'b0);
        chk({name, " end done"}, o_Done, 1'b1);
        chk({name, " end tx"},   o_Tx,   1'b1);
        chk({name, " end sclk"}, o_Sclk, 1'b0);
    endtask

    task automatic launch(input logic [7:0] d, input logic p, input logic [13:0] b);
        i_Data   = d;
        i_Parity = p;
        i_Baud   = b;
        i_Start  = 1'b1;
        @(negedge i_Pclk);
        i_Start  = 1'b0;
    endtask

    initial begin
        i_Presetn = 1'b0;
        i_Start   = 1'b1;
        i_Data    = 8'hFF;
        i_Parity  = 1'b0;
        i_Baud    = 14'd4;

        // Reset held with i_Start high
        repeat (3) begin
            @(negedge i_Pclk);
            chk("rst tx",   o_Tx,   1'b1);
            chk("rst busy", o_Busy, 1'b0);
            chk("rst sclk", o_Sclk, 1'b0);
            chk("rst done", o_Done, 1'b0);
        end
        i_Presetn = 1'b1;
        i_Start   = 1'b0;
        repeat (3) begin
            @(negedge i_Pclk);
            chk("post-rst busy", o_Busy, 1'b0);
            chk("post-rst tx",   o_Tx,   1'b1);
        end

        // 0xA5, no parity, 86 clocks per bit
        seq = '{0,1,0,1,0,0,1,0,1,1,0,0};
        launch(8'hA5, 1'b0, 14'd86);
        check_frame("a5", 10, 86, -1);
        @(negedge i_Pclk);
        chk("a5 done clr", o_Done, 1'b0);
        chk("a5 idle",     o_Busy, 1'b0);

        // 0x07 with even parity, 4 clocks per bit
        seq = '{0,1,1,1,0,0,0,0,0,1,1,0};
        launch(8'h07, 1'b1, 14'd4);
        check_frame("par07", 11, 4, -1);
        @(negedge i_Pclk);
        chk("par07 done clr", o_Done, 1'b0);

        // 0x3C at 10 clocks per bit; baud/parity changed and i_Start pulsed at cycle 25
        seq = '{0,0,0,1,1,1,1,0,0,1,0,0};
        launch(8'h3C, 1'b0, 14'd10);
        check_frame("cfg", 10, 10, 25);
        @(negedge i_Pclk);
        chk("cfg done clr", o_Done, 1'b0);
        chk("cfg no restart", o_Busy, 1'b0);

        // Back-to-back with i_Start held high
        i_Data   = 8'h81;
        i_Parity = 1'b0;
        i_Baud   = 14'd2;
        i_Start  = 1'b1;
        @(negedge i_Pclk);
        seq = '{0,1,0,0,0,0,0,0,1,1,0,0};
        check_frame("b2b1", 10, 2, -1);
        i_Data = 8'h0F;
        @(negedge i_Pclk);
        seq = '{0,1,1,1,1,0,0,0,0,1,0,0};
        check_frame("b2b2", 10, 2, -1);
        i_Start = 1'b0;
        @(negedge i_Pclk);
        chk("b2b idle busy", o_Busy, 1'b0);
        chk("b2b idle done", o_Done, 1'b0);

        // Baud 0 clamps to 2; 0x55 with parity (4 ones -> parity 0)
        seq = '{0,1,0,1,0,1,0,1,0,0,1,0};
        launch(8'h55, 1'b1, 14'd0);
        check_frame("baud0", 11, 2, -1);
        @(negedge i_Pclk);

        // Baud 1 clamps to 2
        seq = '{0,1,0,0,0,0,0,0,0,1,0,0};
        launch(8'h01, 1'b0, 14'd1);
        check_frame("baud1", 10, 2, -1);
        @(negedge i_Pclk);

        // Asynchronous abort in DATA
        launch(8'h00, 1'b0, 14'd4);
        repeat (9) @(negedge i_Pclk);
        chk("abort pre tx",   o_Tx,   1'b0);
        chk("abort pre busy", o_Busy, 1'b1);
        #2 i_Presetn = 1'b0;
        #1;
        chk("abort tx",   o_Tx,   1'b1);
        chk("abort busy", o_Busy, 1'b0);
        chk("abort sclk", o_Sclk, 1'b0);
        repeat (3) begin
            @(negedge i_Pclk);
            chk("abort done", o_Done, 1'b0);
        end
        i_Presetn = 1'b1;
        repeat (4) begin
            @(negedge i_Pclk);
            chk("abort after done", o_Done, 1'b0);
            chk("abort after busy", o_Busy, 1'b0);
            chk("abort after tx",   o_Tx,   1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
